// File: rtl/riscv_params_pkg.sv
// Shared parameters, opcode constants, instruction field layout and FSM
// state type for the instruction encoder/loader.
package riscv_params_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int MEM_DEPTH   = 2**12;
    localparam int ADDR_WIDTH  = 4;

    localparam int OPC_W    = 5;
    localparam int IMM_W    = 18;
    localparam int OFFSET_W = 27;

    // Bit positions inside the 32-bit instruction word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int I_BIT   = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_LSB = 18;
    localparam int RS2_LSB = 14;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd2;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd3;
    localparam logic [OPC_W-1:0] OP_MOD  = 5'd4;
    localparam logic [OPC_W-1:0] OP_CMP  = 5'd5;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd6;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd7;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd8;
    localparam logic [OPC_W-1:0] OP_MOV  = 5'd9;
    localparam logic [OPC_W-1:0] OP_LSL  = 5'd10;
    localparam logic [OPC_W-1:0] OP_LSR  = 5'd11;
    localparam logic [OPC_W-1:0] OP_ASR  = 5'd12;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'd13;
    localparam logic [OPC_W-1:0] OP_LD   = 5'd14;
    localparam logic [OPC_W-1:0] OP_ST   = 5'd15;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'd16;
    localparam logic [OPC_W-1:0] OP_BGT  = 5'd17;
    localparam logic [OPC_W-1:0] OP_B    = 5'd18;
    localparam logic [OPC_W-1:0] OP_CALL = 5'd19;
    localparam logic [OPC_W-1:0] OP_RET  = 5'd20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    // One decoded instruction as offered on the input stream
    typedef struct packed {
        logic [OPC_W-1:0]      opcode;
        logic                  i;
        logic [ADDR_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [IMM_W-1:0]      imm;
        logic [OFFSET_W-1:0]   offset;
    } instr_fields_t;

endpackage

// File: rtl/riscv_instr_encode.sv
// Purely combinational packer: decoded instruction fields -> 32-bit word.
// Fields an opcode does not use are forced to zero.
module riscv_instr_encode
    import riscv_params_pkg::*;
(
    input  instr_fields_t          fields,
    output logic [INSTR_WIDTH-1:0] word
);

    // Select the format from the opcode and place each used field
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        word = '0;
        word[OPC_MSB:OPC_LSB] = fields.opcode;
        case (fields.opcode)
            OP_B, OP_BEQ, OP_BGT, OP_CALL: word[OFFSET_W-1:0] = fields.offset;
            OP_NOP, OP_RET: ;
            default: begin
                // ALU / LD / ST format; opcodes above RET also land here and are packed raw
                word[I_BIT] = fields.i;
                if (fields.opcode != OP_CMP)
                    word[RD_LSB +: ADDR_WIDTH] = fields.rd;
                if (fields.opcode != OP_MOV && fields.opcode != OP_NOT)
                    word[RS1_LSB +: ADDR_WIDTH] = fields.rs1;
                if (fields.i)
                    word[IMM_W-1:0] = fields.imm;
                else
                    word[RS2_LSB +: ADDR_WIDTH] = fields.rs2;
            end
        endcase
    end

endmodule

// File: rtl/riscv_instr_encoder_loader.sv
// Instruction-memory writer: accepts decoded field bundles on a valid/ready
// stream, encodes each into a 32-bit word and writes it to consecutive
// addresses starting at BASE_ADDR. busy holds the core off until the image
// is loaded. Optional build macro ENC_ILLEGAL_CHK_EN adds err_illegal and
// drops opcodes above RET instead of writing them.
module riscv_instr_encoder_loader #(
    parameter int MEM_DEPTH = riscv_params_pkg::MEM_DEPTH,
    parameter int BASE_ADDR = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [4:0]                                in_opcode,
    input  logic                                      in_I,
    input  logic [riscv_params_pkg::ADDR_WIDTH-1:0]   in_rd,
    input  logic [riscv_params_pkg::ADDR_WIDTH-1:0]   in_rs1,
    input  logic [riscv_params_pkg::ADDR_WIDTH-1:0]   in_rs2,
    input  logic [17:0]                               in_imm,
    input  logic [26:0]                               in_offset,
    input  logic                                      in_last,
    output logic                                      mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]              mem_addr,
    output logic [riscv_params_pkg::INSTR_WIDTH-1:0]  mem_wdata,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err_overflow,
    output logic [$clog2(MEM_DEPTH):0]                instr_count
`ifdef ENC_ILLEGAL_CHK_EN
    ,
    output logic                                      err_illegal
`endif
);

    import riscv_params_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH);
    // Pointer carries one extra bit so "one past the last word" is representable
    localparam logic [AW:0] BASE_PTR = (AW+1)'(BASE_ADDR);
    localparam logic [AW:0] END_PTR  = (AW+1)'(MEM_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    enc_state_t             state_q, state_d;
    logic [AW:0]            ptr_q, ptr_d;
    logic                   mem_we_q, mem_we_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [INSTR_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                   err_overflow_q, err_overflow_d;
`ifdef ENC_ILLEGAL_CHK_EN
    logic                   err_illegal_q, err_illegal_d;
`endif

    instr_fields_t          in_fields;
    logic [INSTR_WIDTH-1:0] enc_word;
    logic                   full;
    logic                   accept;
    logic                   opcode_ok;

    assign in_fields = '{opcode: in_opcode, i: in_I, rd: in_rd, rs1: in_rs1,
                         rs2: in_rs2, imm: in_imm, offset: in_offset};

    riscv_instr_encode u_encode (
        .fields (in_fields),
        .word   (enc_word)
    );

    assign full   = (ptr_q - BASE_PTR) == (END_PTR - BASE_PTR);
    assign accept = in_valid & in_ready;
`ifdef ENC_ILLEGAL_CHK_EN
    assign opcode_ok = (in_opcode <= OP_RET);
`else
    assign opcode_ok = 1'b1;
`endif

    // State and output registers; synchronous reset also cancels a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= BASE_PTR;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= BASE_PTR[AW-1:0];
            mem_wdata_q    <= '0;
            err_overflow_q <= 1'b0;
`ifdef ENC_ILLEGAL_CHK_EN
            err_illegal_q  <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            err_overflow_q <= err_overflow_d;
`ifdef ENC_ILLEGAL_CHK_EN
            err_illegal_q  <= err_illegal_d;
`endif
        end
    end

    // Next-state, pointer and write-strobe logic
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        err_overflow_d = err_overflow_q;
`ifdef ENC_ILLEGAL_CHK_EN
        err_illegal_d  = err_illegal_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = LOAD;
                    ptr_d          = BASE_PTR;
                    err_overflow_d = 1'b0;
`ifdef ENC_ILLEGAL_CHK_EN
                    err_illegal_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (in_valid && full) begin
                    // Bundle offered with no room left: flag and stop the session
                    err_overflow_d = 1'b1;
                    state_d        = DONE;
                end else if (accept) begin
                    if (opcode_ok) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q[AW-1:0];
                        mem_wdata_d = enc_word;
                        ptr_d       = ptr_q + PTR_ONE;
                    end
`ifdef ENC_ILLEGAL_CHK_EN
                    else begin
                        err_illegal_d = 1'b1;
                    end
`endif
                    if (in_last)
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        in_ready = (state_q == LOAD) && !full;
        busy     = (state_q == LOAD);
        done     = (state_q == DONE);
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign err_overflow = err_overflow_q;
    assign instr_count  = ptr_q - BASE_PTR;
`ifdef ENC_ILLEGAL_CHK_EN
    assign err_illegal  = err_illegal_q;
`endif

endmodule

// File: tb/tb_riscv_instr_encoder_loader.sv
// Scoreboard bench for riscv_instr_encoder_loader. A full-size instance
// carries most of the traffic; a 4-word instance (enabled only where needed)
// covers the memory-full boundary.
`timescale 1ns/1ps
module tb_riscv_instr_encoder_loader;

    import riscv_params_pkg::*;

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int SAW = 2;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_I, in_last;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rd, in_rs1, in_rs2;
    logic [17:0] in_imm;
    logic [26:0] in_offset;

    logic          in_ready, mem_we, busy, done, err_overflow;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   instr_count;

    logic           small_en;
    logic           s_start, s_in_valid;
    logic           s_in_ready, s_mem_we, s_busy, s_done, s_err_overflow;
    logic [SAW-1:0] s_mem_addr;
    logic [31:0]    s_mem_wdata;
    logic [SAW:0]   s_instr_count;
`ifdef ENC_ILLEGAL_CHK_EN
    logic err_illegal, s_err_illegal;
`endif

    assign s_start    = start & small_en;
    assign s_in_valid = in_valid & small_en;

    riscv_instr_encoder_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_I(in_I), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_offset(in_offset), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err_overflow(err_overflow), .instr_count(instr_count)
`ifdef ENC_ILLEGAL_CHK_EN
        , .err_illegal(err_illegal)
`endif
    );

    riscv_instr_encoder_loader #(.MEM_DEPTH(4), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_opcode(in_opcode), .in_I(in_I), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_offset(in_offset), .in_last(in_last),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .busy(s_busy), .done(s_done), .err_overflow(s_err_overflow), .instr_count(s_instr_count)
`ifdef ENC_ILLEGAL_CHK_EN
        , .err_illegal(s_err_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] word;
    } wr_t;

    wr_t main_q[$];
    wr_t small_q[$];
    int  main_ptr   = 0;
    int  small_ptr  = 0;
    bit  small_live = 0;
    int  n_checks   = 0;
    int  n_fail     = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Independent reference encoding
    function automatic logic [31:0] model(input instr_fields_t f);
        logic [26:0] body;
        logic [17:0] src2;
        src2 = f.i ? f.imm : {f.rs2, 14'h0};
        case (f.opcode)
            5'd16, 5'd17, 5'd18, 5'd19: body = f.offset;
            5'd13, 5'd20:               body = '0;
            5'd5:                       body = {f.i, 4'h0, f.rs1, src2};
            5'd8, 5'd9:                 body = {f.i, f.rd, 4'h0, src2};
            default:                    body = {f.i, f.rd, f.rs1, src2};
        endcase
        return {f.opcode, body};
    endfunction

    function automatic bit writes(input logic [4:0] op);
`ifdef ENC_ILLEGAL_CHK_EN
        return op <= 5'd20;
`else
        return (op == op) ? 1'b1 : 1'b0;
`endif
    endfunction

    function automatic instr_fields_t mk(input int op, input bit i, input int rd, input int rs1,
                                         input int rs2, input int imm, input int off);
        instr_fields_t f;
        f.opcode = 5'(op);  f.i = i;
        f.rd = 4'(rd);      f.rs1 = 4'(rs1);  f.rs2 = 4'(rs2);
        f.imm = 18'(imm);   f.offset = 27'(off);
        return f;
    endfunction

    function automatic instr_fields_t rnd(input int op_lo, input int op_hi);
        return mk($urandom_range(op_hi, op_lo), 1'($urandom), $urandom_range(15, 0),
                  $urandom_range(15, 0), $urandom_range(15, 0), $urandom, $urandom);
    endfunction

    // Write monitors: pop the oldest expected write whenever a strobe is seen
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (main_q.size() == 0) begin
                check("main_unexpected_write", 1, 0);
            end else begin
                e = main_q.pop_front();
                check("main_addr", 64'(mem_addr), 64'(e.addr));
                check("main_wdata", 64'(mem_wdata), 64'(e.word));
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (s_mem_we === 1'b1) begin
            if (small_q.size() == 0) begin
                check("small_unexpected_write", 1, 0);
            end else begin
                e = small_q.pop_front();
                check("small_addr", 64'(s_mem_addr), 64'(e.addr));
                check("small_wdata", 64'(s_mem_wdata), 64'(e.word));
            end
        end
    end

    // Present one bundle for exactly one clock edge and record what must be written
    task automatic send(input instr_fields_t f, input logic last, input logic [31:0] exp_w);
        in_opcode = f.opcode; in_I = f.i; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
        in_imm = f.imm; in_offset = f.offset; in_last = last; in_valid = 1'b1;
        check("main_in_ready", 64'(in_ready), 1);
        if (writes(f.opcode)) begin
            main_q.push_back('{addr: main_ptr, word: exp_w});
            main_ptr++;
        end
        if (small_en) begin
            check("small_in_ready", 64'(s_in_ready), 64'(small_live && small_ptr < 4));
            if (small_live) begin
                if (small_ptr < 4) begin
                    if (writes(f.opcode)) begin
                        small_q.push_back('{addr: small_ptr, word: exp_w});
                        small_ptr++;
                    end
                    if (last) small_live = 0;
                end else begin
                    small_live = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        main_ptr = 0;
        if (small_en) begin
            small_ptr  = 0;
            small_live = 1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 0);
        check({tag, "_mem_we"}, 64'(mem_we), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_err_overflow"}, 64'(err_overflow), 0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
        check({tag, "_instr_count"}, 64'(instr_count), 0);
`ifdef ENC_ILLEGAL_CHK_EN
        check({tag, "_err_illegal"}, 64'(err_illegal), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_fields_t f;
        bit            last;
        rst = 1'b1; start = 1'b0; small_en = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_opcode = '0; in_I = 1'b0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_offset = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: single ADD with in_last
        start_session();
        check("t1_busy", 64'(busy), 1);
        check("t1_count0", 64'(instr_count), 0);
        send(mk(0, 0, 3, 1, 2, 0, 0), 1'b1, 32'h00C48000);
        check("t1_done", 64'(done), 1);
        check("t1_count", 64'(instr_count), 1);
        check("t1_busy_low", 64'(busy), 0);
        check("t1_ready_low", 64'(in_ready), 0);
        idle(1);

        // 2: MOV / BEQ / RET back to back, unused fields carry junk
        start_session();
        send(mk(9, 1, 5, 7, 9, 'h0000A, 'h5A5A5), 1'b0, 32'h4D40000A);
        send(mk(16, 1, 6, 3, 11, 'h3FFFF, 'h10), 1'b0, 32'h80000010);
        send(mk(20, 1, 15, 15, 15, 'h3FFFF, 'h7FFFFFF), 1'b1, 32'hA0000000);
        check("t2_count", 64'(instr_count), 3);
        check("t2_done", 64'(done), 1);
        idle(1);

        // 3a: 4-word memory, five bundles without in_last -> overflow on the fifth
        small_en = 1'b1;
        start_session();
        for (int k = 0; k < 5; k++) begin
            f = rnd(0, 12);
            send(f, 1'b0, model(f));
        end
        check("t3_s_err_overflow", 64'(s_err_overflow), 1);
        check("t3_s_done", 64'(s_done), 1);
        check("t3_s_count", 64'(s_instr_count), 4);
        check("t3_s_busy", 64'(s_busy), 0);
        check("t3_main_count", 64'(instr_count), 5);
        check("t3_main_no_ovf", 64'(err_overflow), 0);
        f = rnd(14, 15);
        send(f, 1'b1, model(f));
        check("t3_main_count_end", 64'(instr_count), 6);

        // 3b: in_last on the bundle that fills the last word is a clean finish
        start_session();
        check("t3_s_ovf_cleared", 64'(s_err_overflow), 0);
        for (int k = 0; k < 4; k++) begin
            f = rnd(0, 12);
            send(f, k == 3, model(f));
        end
        check("t3_s_fill_done", 64'(s_done), 1);
        check("t3_s_fill_no_ovf", 64'(s_err_overflow), 0);
        check("t3_s_fill_count", 64'(s_instr_count), 4);
        idle(1);
        small_en = 1'b0;

        // 4: reset sampled together with an accept cancels the write
        start_session();
        for (int k = 0; k < 2; k++) begin
            f = rnd(0, 20);
            send(f, 1'b0, model(f));
        end
        f = rnd(0, 12);
        in_opcode = f.opcode; in_I = f.i; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
        in_imm = f.imm; in_offset = f.offset; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        idle(1);
        check("t4_no_pending", 64'(main_q.size()), 0);
        start_session();
        f = rnd(0, 20);
        send(f, 1'b1, model(f));
        check("t4_reload_count", 64'(instr_count), 1);
        idle(1);

        // 5: random gaps, random opcodes, start pulses during LOAD
        start_session();
        for (int k = 0; k < 24; k++) begin
            start = ($urandom_range(3, 0) == 0);
            idle($urandom_range(2, 0));
            start = ($urandom_range(3, 0) == 0);
            f = rnd(0, 31);
            last = (k == 23);
            send(f, last, model(f));
            start = 1'b0;
        end
        check("t5_count", 64'(instr_count), 64'(main_ptr));
        check("t5_done", 64'(done), 1);
        idle(1);

        // 6: out-of-range opcode between two NOPs
        start_session();
        f = mk(13, 1, 4, 4, 4, 'h1234, 'h999);
        send(f, 1'b0, model(f));
        f = mk(31, 0, 2, 6, 10, 'h2AAAA, 'h123);
        send(f, 1'b0, model(f));
        f = mk(13, 0, 9, 9, 9, 'h0, 'h1);
        send(f, 1'b1, model(f));
`ifdef ENC_ILLEGAL_CHK_EN
        check("t6_err_illegal", 64'(err_illegal), 1);
        check("t6_count", 64'(instr_count), 2);
        idle(1);
        start_session();
        check("t6_illegal_cleared", 64'(err_illegal), 0);
        f = mk(13, 0, 0, 0, 0, 0, 0);
        send(f, 1'b1, model(f));
`else
        check("t6_count", 64'(instr_count), 3);
`endif
        check("t6_no_ovf", 64'(err_overflow), 0);

        idle(3);
        check("main_q_drained", 64'(main_q.size()), 0);
        check("small_q_drained", 64'(small_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
